// File: rtl/controlador_sensor_distancia_if.sv
// controlador_sensor_distancia_if: sensor controller request, echo, trigger and mapping-ROM signals.
// master drives requests, echo and ROM data; slave is the controller.
interface controlador_sensor_distancia_if;
    logic       start;
    logic       echo;
    logic       trig;
    logic [8:0] distancia;
    logic [7:0] distancia_mapeada;
    logic [7:0] valor;
    logic       valid;
    logic       busy;
    logic       timeout;
    modport master (output start, echo, distancia_mapeada,
                    input  trig, distancia, valor, valid, busy, timeout);
    modport slave  (input  start, echo, distancia_mapeada,
                    output trig, distancia, valor, valid, busy, timeout);
endinterface

// File: rtl/controlador_sensor_distancia.sv
// controlador_sensor_distancia: ultrasonic ranger controller (trigger, echo timing, ROM lookup).
// Define SENSOR_CONTINUO_EN to auto-start a measurement every PERIOD_CYCLES.
module controlador_sensor_distancia #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int PERIOD_CYCLES  = 3000000
) (
    input logic clk,
    input logic reset,
    controlador_sensor_distancia_if.slave sif
);
    localparam int CMAX = TIMEOUT_CYCLES > TRIG_CYCLES ? TIMEOUT_CYCLES : TRIG_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(CYCLES_PER_CM + 1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_ECHO, MEASURE, LOOKUP, DONE} state_t;

    state_t          state, next;
    logic            s1, s2, go, tmo, wrap, timeout_q;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   sub;
    logic [4:0]      cm;
    logic [7:0]      valor_q;

    assign tmo  = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign wrap = sub == SW'(CYCLES_PER_CM - 1);

`ifdef SENSOR_CONTINUO_EN
    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    logic [PW-1:0] pcnt;
    logic          run;
    assign go = state == IDLE && (sif.start || (run && pcnt == PW'(PERIOD_CYCLES - 1)));
    // Saturating start-to-start timer; only armed after the first accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            run  <= 1'b0;
        end else if (go) begin
            pcnt <= '0;
            run  <= 1'b1;
        end else if (pcnt != PW'(PERIOD_CYCLES - 1)) begin
            pcnt <= pcnt + 1'b1;
        end
    end
`else
    assign go = state == IDLE && sif.start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:      next = go ? TRIG : IDLE;
            TRIG:      next = cnt == CW'(TRIG_CYCLES - 1) ? WAIT_ECHO : TRIG;
            WAIT_ECHO: next = s2 ? MEASURE : tmo ? IDLE : WAIT_ECHO;
            MEASURE:   next = (!s2 || tmo) ? LOOKUP : MEASURE;
            LOOKUP:    next = DONE;
            DONE:      next = IDLE;
            default:   next = IDLE;
        endcase
    end

    // The cycle that detects echo in WAIT_ECHO is counted so cm reflects the full echo width
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            cnt       <= '0;
            sub       <= '0;
            cm        <= '0;
            timeout_q <= 1'b0;
            valor_q   <= '0;
        end else begin
            s1  <= sif.echo;
            s2  <= s1;
            cnt <= next != state ? '0 : cnt + 1'b1;
            if (go) begin
                sub       <= '0;
                cm        <= '0;
                timeout_q <= 1'b0;
            end else if (state == MEASURE && s2 && tmo) begin
                cm        <= 5'd16;
                timeout_q <= 1'b1;
            end else if ((state == WAIT_ECHO || state == MEASURE) && s2) begin
                sub <= wrap ? '0 : sub + 1'b1;
                cm  <= (wrap && cm != 5'd16) ? cm + 5'd1 : cm;
            end else if (state == WAIT_ECHO && tmo) begin
                timeout_q <= 1'b1;
            end
            if (state == LOOKUP) valor_q <= sif.distancia_mapeada;
        end
    end

    assign sif.distancia = cm < 5'd5 ? 9'd0 : cm > 5'd15 ? 9'd10 : 9'(cm - 5'd5);
    assign sif.trig      = state == TRIG;
    assign sif.busy      = state != IDLE;
    assign sif.valid     = state == DONE;
    assign sif.timeout   = timeout_q;
    assign sif.valor     = valor_q;
endmodule

// File: tb/tb_controlador_sensor_distancia.sv
// tb_controlador_sensor_distancia: randomized and directed checks against a distance model.
// Define SENSOR_CONTINUO_EN to check auto-restart spacing instead of single measurements.
module tb_controlador_sensor_distancia;
    localparam int TRIG = 20;
    localparam int CPC  = 10;
    localparam int TOUT = 400;
    localparam int PER  = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    controlador_sensor_distancia_if ifc ();

    controlador_sensor_distancia #(
        .TRIG_CYCLES(TRIG), .CYCLES_PER_CM(CPC), .TIMEOUT_CYCLES(TOUT), .PERIOD_CYCLES(PER)
    ) dut (
        .clk(clk), .reset(reset), .sif(ifc)
    );

    always #5 clk = ~clk;

    // Sensor mapping ROM: linear 0..10 -> 0..255
    function automatic logic [7:0] rom(input logic [8:0] a);
        int v;
        v = (int'(a) * 51 + 1) / 2;
        return v > 255 ? 8'd255 : 8'(v);
    endfunction

    function automatic int exp_dist(input int n);
        int c;
        c = n / CPC > 16 ? 16 : n / CPC;
        return c < 5 ? 0 : c > 15 ? 10 : c - 5;
    endfunction

    assign ifc.distancia_mapeada = rom(ifc.distancia);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_trig;
        int tw;
        tw = 0;
        ifc.start = 1'b1;
        tick;
        ifc.start = 1'b0;
        chk("busy_after_start", 32'(ifc.busy), 1);
        chk("timeout_cleared", 32'(ifc.timeout), 0);
        while (ifc.trig === 1'b1 && tw < 10 * TRIG) begin
            tw++;
            tick;
        end
        chk("trig_width", tw, TRIG);
    endtask

    task automatic measure(input int n, input int pre);
        int lat;
        start_trig;
        repeat (pre) tick;
        ifc.echo = 1'b1;
        for (int i = 0; i < n; i++) begin
            ifc.start = (i == n / 2);
            tick;
        end
        ifc.start = 1'b0;
        ifc.echo = 1'b0;
        lat = 0;
        while (ifc.valid !== 1'b1 && lat < 50) begin
            tick;
            lat++;
        end
        chk("valid_latency", lat, 4);
        chk("valor", 32'(ifc.valor), 32'(rom(9'(exp_dist(n)))));
        chk("distancia", 32'(ifc.distancia), exp_dist(n));
        ifc.start = 1'b1;
        tick;
        ifc.start = 1'b0;
        chk("valid_one_cycle", 32'(ifc.valid), 0);
        chk("start_in_done_ignored", 32'(ifc.busy), 0);
    endtask

    initial begin
        int c, seen, prev_valor;
        ifc.start = 1'b0;
        ifc.echo = 1'b0;
        repeat (3) tick;
        chk("rst_trig", 32'(ifc.trig), 0);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_valid", 32'(ifc.valid), 0);
        chk("rst_timeout", 32'(ifc.timeout), 0);
        chk("rst_valor", 32'(ifc.valor), 0);
        chk("rst_distancia", 32'(ifc.distancia), 0);
        reset = 1'b0;
        tick;
`ifdef SENSOR_CONTINUO_EN
        begin
            int rise[4];
            int k, w;
            logic prev;
            k = 0;
            w = 0;
            prev = 1'b0;
            ifc.start = 1'b1;
            for (int i = 0; i < 6 * PER && k < 4; i++) begin
                tick;
                ifc.start = 1'b0;
                if (ifc.trig === 1'b1 && !prev) begin
                    rise[k] = i;
                    k++;
                end
                if (ifc.trig === 1'b1 && k == 1) w++;
                prev = ifc.trig;
            end
            chk("auto_pulses", k, 4);
            chk("auto_trig_width", w, TRIG);
            for (int j = 1; j < 4; j++) chk("auto_period", rise[j] - rise[j-1], PER);
        end
`else
        measure(10 * CPC, 3);
        measure(2 * CPC, 0);
        measure(30 * CPC, 7);
        for (int r = 0; r < 6; r++) measure(int'($urandom_range(1, 250)), int'($urandom_range(0, 20)));
        prev_valor = int'(ifc.valor);
        start_trig;
        c = 0;
        seen = 0;
        while (ifc.busy === 1'b1 && c < 2 * TOUT) begin
            if (ifc.valid === 1'b1) seen++;
            tick;
            c++;
        end
        chk("echo_wait_cycles", c, TOUT);
        chk("echo_wait_timeout", 32'(ifc.timeout), 1);
        chk("echo_wait_no_valid", seen, 0);
        chk("echo_wait_valor_kept", 32'(ifc.valor), prev_valor);
        measure(int'($urandom_range(50, 120)), 2);
        start_trig;
        ifc.echo = 1'b1;
        c = 0;
        while (ifc.valid !== 1'b1 && c < 3 * TOUT) begin
            tick;
            c++;
        end
        chk("meas_tmo_valor", 32'(ifc.valor), 255);
        chk("meas_tmo_flag", 32'(ifc.timeout), 1);
        chk("meas_tmo_dist", 32'(ifc.distancia), 10);
        ifc.echo = 1'b0;
        repeat (5) tick;
        start_trig;
        ifc.echo = 1'b1;
        repeat (30) tick;
        reset = 1'b1;
        #1;
        chk("abort_trig", 32'(ifc.trig), 0);
        chk("abort_busy", 32'(ifc.busy), 0);
        chk("abort_valid", 32'(ifc.valid), 0);
        chk("abort_timeout", 32'(ifc.timeout), 0);
        chk("abort_valor", 32'(ifc.valor), 0);
        chk("abort_distancia", 32'(ifc.distancia), 0);
        repeat (2) tick;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) ifc.echo = 1'b0;
            tick;
            if (ifc.valid === 1'b1 || ifc.busy === 1'b1) seen++;
        end
        chk("abort_stays_idle", seen, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
